trace_buf_reader: RTL and testbench



---
 rtl/trace_buf_pkg.sv | 20 ++
 rtl/trace_beat_serializer.sv | 50 +++++
 rtl/trace_buf_reader.sv | 131 +++++++++++++
 tb/tb_trace_buf_reader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_buf_pkg.sv
// Shared definitions for the trace buffer readout path: width defaults,
// beats per stored word and the reader FSM encoding.
package trace_buf_pkg;

  localparam int VECTOR_DATA_WIDTH_DEF    = 192;
  localparam int TRACE_BUF_DATA_WIDTH_DEF = 256;
  localparam int TRACE_BUF_ADDR_WIDTH_DEF = 15;
  localparam int OUT_DATA_WIDTH_DEF       = 32;
  localparam int BRAM_RD_LATENCY_DEF      = 2;
  localparam int BEATS_PER_WORD_DEF       = VECTOR_DATA_WIDTH_DEF / OUT_DATA_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/trace_beat_serializer.sv
// Splits one captured trace word into stream beats, least-significant slice
// first, holding data stable under back-pressure and flagging the final beat.
module trace_beat_serializer
  import trace_buf_pkg::*;
#(
  parameter int VECTOR_DATA_WIDTH = VECTOR_DATA_WIDTH_DEF,
  parameter int OUT_DATA_WIDTH    = OUT_DATA_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [VECTOR_DATA_WIDTH-1:0] load_data,
  input  logic                         active,
  input  logic                         last_word,
  input  logic                         m_tready,
  output logic [OUT_DATA_WIDTH-1:0]    m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic                         word_done
);

  localparam int BEATS  = VECTOR_DATA_WIDTH / OUT_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [VECTOR_DATA_WIDTH-1:0] shift_reg;
  logic [BEAT_W-1:0]            beat_cnt_reg;
  logic                         beat_fire;

  assign m_tvalid  = active;
  assign m_tdata   = shift_reg[OUT_DATA_WIDTH-1:0];
  assign m_tlast   = active && last_word && (beat_cnt_reg == LAST_BEAT);
  assign beat_fire = active && m_tready;
  assign word_done = beat_fire && (beat_cnt_reg == LAST_BEAT);

  // The register only moves on an accepted beat, so a stalled beat stays put.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      beat_cnt_reg <= '0;
    end else if (load) begin
      shift_reg    <= load_data;
      beat_cnt_reg <= '0;
    end else if (beat_fire) begin
      shift_reg    <= shift_reg >> OUT_DATA_WIDTH;
      beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
    end
  end

endmodule

// File: rtl/trace_buf_reader.sv
// Reads a run of trace words from BRAM port B and streams each word out as
// fixed-width beats, with a busy flag and a one-cycle completion pulse.
module trace_buf_reader
  import trace_buf_pkg::*;
#(
  parameter int VECTOR_DATA_WIDTH    = VECTOR_DATA_WIDTH_DEF,
  parameter int TRACE_BUF_DATA_WIDTH = TRACE_BUF_DATA_WIDTH_DEF,
  parameter int TRACE_BUF_ADDR_WIDTH = TRACE_BUF_ADDR_WIDTH_DEF,
  parameter int OUT_DATA_WIDTH       = OUT_DATA_WIDTH_DEF,
  parameter int BRAM_RD_LATENCY      = BRAM_RD_LATENCY_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [TRACE_BUF_ADDR_WIDTH-1:0] start_addr,
  input  logic [TRACE_BUF_ADDR_WIDTH:0]   word_count,
  output logic [TRACE_BUF_ADDR_WIDTH-1:0] trace_buf_bram_addrb,
  output logic                            trace_buf_enb,
  input  logic [TRACE_BUF_DATA_WIDTH-1:0] trace_buf_bram_data_out,
  output logic [OUT_DATA_WIDTH-1:0]       m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done
);

  localparam logic [2:0] WAIT_LAST = 3'(BRAM_RD_LATENCY - 1);
  localparam logic [TRACE_BUF_ADDR_WIDTH:0] ONE_WORD = (TRACE_BUF_ADDR_WIDTH + 1)'(1);

  state_t                          state_reg, state_next;
  logic [TRACE_BUF_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [TRACE_BUF_ADDR_WIDTH:0]   words_left_reg, words_left_next;
  logic [2:0]                      wait_cnt_reg, wait_cnt_next;
  logic                            capture;
  logic                            word_done;
  logic                            last_word;

  assign last_word = (words_left_reg == ONE_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      words_left_reg <= '0;
      wait_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      words_left_reg <= words_left_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    words_left_next = words_left_reg;
    wait_cnt_next   = wait_cnt_reg;
    capture         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            state_next      = ISSUE;
            addr_next       = start_addr;
            words_left_next = word_count;
          end else begin
            state_next = DONE;
          end
        end
      end
      ISSUE: begin
        state_next    = WAIT;
        wait_cnt_next = '0;
      end
      WAIT: begin
        // Read data is valid in the last cycle of the latency window.
        if (wait_cnt_reg == WAIT_LAST) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 3'd1;
        end
      end
      SHIFT: begin
        if (word_done) begin
          words_left_next = words_left_reg - ONE_WORD;
          if (last_word) begin
            state_next = DONE;
          end else begin
            state_next = ISSUE;
            addr_next  = addr_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign trace_buf_bram_addrb = addr_reg;
  assign trace_buf_enb        = (state_reg == ISSUE);
  assign busy                 = (state_reg != IDLE);
  assign done                 = (state_reg == DONE);

  generate
    if (TRACE_BUF_DATA_WIDTH > VECTOR_DATA_WIDTH) begin : g_upper
      logic unused_upper_bits;
      assign unused_upper_bits = ^trace_buf_bram_data_out[TRACE_BUF_DATA_WIDTH-1:VECTOR_DATA_WIDTH];
    end
  endgenerate

  trace_beat_serializer #(
    .VECTOR_DATA_WIDTH (VECTOR_DATA_WIDTH),
    .OUT_DATA_WIDTH    (OUT_DATA_WIDTH)
  ) u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (trace_buf_bram_data_out[VECTOR_DATA_WIDTH-1:0]),
    .active    (state_reg == SHIFT),
    .last_word (last_word),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tlast   (m_tlast),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_trace_buf_reader.sv
// Directed bench for trace_buf_reader: BRAM model with two-cycle read latency,
// stream monitor, and one task per scenario.
module tb_trace_buf_reader;

  localparam int L = 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [14:0]  start_addr;
  logic [15:0]  word_count;
  logic [14:0]  trace_buf_bram_addrb;
  logic         trace_buf_enb;
  logic [255:0] trace_buf_bram_data_out;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;

  logic [14:0] addr_q[$];
  logic [31:0] data_q[$];
  logic        last_q[$];
  int first_enb_cyc, first_valid_cyc, last_cyc, done_cnt, done_cyc, tvalid_seen;
  int stall_viol, stall_checks;
  logic prev_stall;
  logic [31:0] prev_data;
  logic prev_last;

  trace_buf_reader dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .start_addr              (start_addr),
    .word_count              (word_count),
    .trace_buf_bram_addrb    (trace_buf_bram_addrb),
    .trace_buf_enb           (trace_buf_enb),
    .trace_buf_bram_data_out (trace_buf_bram_data_out),
    .m_tdata                 (m_tdata),
    .m_tvalid                (m_tvalid),
    .m_tready                (m_tready),
    .m_tlast                 (m_tlast),
    .busy                    (busy),
    .done                    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] beat_val(input logic [14:0] a, input int j);
    logic [7:0] jb;
    jb = 8'(j);
    return {1'b0, a, jb, 8'h5A};
  endfunction

  function automatic logic [255:0] word_val(input logic [14:0] a);
    logic [255:0] w;
    w = {256{1'b1}};
    for (int j = 0; j < 6; j++) w[j*32 +: 32] = beat_val(a, j);
    return w;
  endfunction

  // BRAM port B with a two-stage registered read
  logic [255:0] rd_pipe1, rd_pipe2;
  always @(posedge clk) begin
    if (trace_buf_enb) rd_pipe1 <= word_val(trace_buf_bram_addrb);
    rd_pipe2 <= rd_pipe1;
  end
  assign trace_buf_bram_data_out = rd_pipe2;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (trace_buf_enb) begin
        addr_q.push_back(trace_buf_bram_addrb);
        if (first_enb_cyc < 0) first_enb_cyc = cyc;
      end
      if (m_tvalid) begin
        tvalid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (m_tvalid && m_tready) begin
        data_q.push_back(m_tdata);
        last_q.push_back(m_tlast);
        if (m_tlast) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_stall && m_tvalid) begin
        stall_checks++;
        if (m_tdata !== prev_data || m_tlast !== prev_last) stall_viol++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  task automatic clear_mon();
    addr_q.delete();
    data_q.delete();
    last_q.delete();
    first_enb_cyc = -1;
    first_valid_cyc = -1;
    last_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    tvalid_seen = 0;
    stall_viol = 0;
    stall_checks = 0;
    prev_stall = 1'b0;
  endtask

  task automatic do_start(input logic [14:0] a, input logic [15:0] n);
    @(posedge clk); #1;
    clear_mon();
    start_addr = a;
    word_count = n;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      $display("FAIL %s timeout: no done within %0d cycles", name, budget);
      errors++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({trace_buf_enb, m_tvalid, m_tlast, busy, done} !== 5'b0) begin
      $display("FAIL reset_flags: enb/tvalid/tlast/busy/done=%b required 00000",
               {trace_buf_enb, m_tvalid, m_tlast, busy, done});
      errors++;
    end
    checks++;
    if (trace_buf_bram_addrb !== 15'h0) begin
      $display("FAIL reset_addrb: got %h required 0000", trace_buf_bram_addrb);
      errors++;
    end
    checks++;
    if (m_tdata !== 32'h0) begin
      $display("FAIL reset_tdata: got %h required 00000000", m_tdata);
      errors++;
    end
  endtask

  task automatic test_two_words();
    logic [14:0] ea;
    m_tready = 1'b1;
    do_start(15'h0010, 16'd2);
    wait_done("two_words", 200);
    checks++;
    if (data_q.size() != 12) begin
      $display("FAIL two_words beat_count: got %0d required 12", data_q.size());
      errors++;
    end
    for (int k = 0; k < data_q.size() && k < 12; k++) begin
      ea = 15'h0010 + 15'(k / 6);
      checks++;
      if (data_q[k] !== beat_val(ea, k % 6)) begin
        $display("FAIL two_words beat%0d data: got %h required %h", k, data_q[k], beat_val(ea, k % 6));
        errors++;
      end
      checks++;
      if (last_q[k] !== (k == 11)) begin
        $display("FAIL two_words beat%0d tlast: got %b required %b", k, last_q[k], (k == 11));
        errors++;
      end
    end
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 15'h0010 || addr_q[1] !== 15'h0011) begin
      $display("FAIL two_words addrb: got %0d reads first %h required 2 reads 0010,0011",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 15'h7FFF);
      errors++;
    end
    checks++;
    if (first_enb_cyc != start_cyc + 1) begin
      $display("FAIL two_words enb_latency: got %0d required %0d", first_enb_cyc - start_cyc, 1);
      errors++;
    end
    checks++;
    if (first_valid_cyc != start_cyc + 2 + L) begin
      $display("FAIL two_words tvalid_latency: got %0d required %0d", first_valid_cyc - start_cyc, 2 + L);
      errors++;
    end
    checks++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      $display("FAIL two_words done: pulses %0d at +%0d after tlast required 1 at +1", done_cnt, done_cyc - last_cyc);
      errors++;
    end
  endtask

  task automatic test_zero_count();
    m_tready = 1'b1;
    do_start(15'h0020, 16'd0);
    wait_done("zero_count", 20);
    checks++;
    if (addr_q.size() != 0 || tvalid_seen != 0) begin
      $display("FAIL zero_count activity: enb %0d tvalid %0d required 0 0", addr_q.size(), tvalid_seen);
      errors++;
    end
    checks++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1) begin
      $display("FAIL zero_count done: pulses %0d at +%0d required 1 at +1", done_cnt, done_cyc - start_cyc);
      errors++;
    end
  endtask

  task automatic test_wrap();
    m_tready = 1'b1;
    do_start(15'h7FFF, 16'd2);
    wait_done("wrap", 200);
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 15'h7FFF || addr_q[1] !== 15'h0000) begin
      $display("FAIL wrap addrb: got %0d reads last %h required 7FFF,0000",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[addr_q.size()-1] : 15'h1234);
      errors++;
    end
    checks++;
    if (data_q.size() != 12 || data_q[6] !== beat_val(15'h0000, 0)) begin
      $display("FAIL wrap word1_beat0: beats %0d data %h required 12 beats with %h",
               data_q.size(), (data_q.size() > 6) ? data_q[6] : 32'h0, beat_val(15'h0000, 0));
      errors++;
    end
  endtask

  task automatic test_backpressure();
    int n;
    m_tready = 1'b1;
    do_start(15'h0123, 16'd1);
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk); #1;
      m_tready = ~m_tready;
      n++;
    end
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != 1) begin
      $display("FAIL backpressure done: got %0d pulses required 1", done_cnt);
      errors++;
    end
    checks++;
    if (stall_checks == 0 || stall_viol != 0) begin
      $display("FAIL backpressure stability: stalls %0d unstable %0d required >0 and 0", stall_checks, stall_viol);
      errors++;
    end
    checks++;
    if (data_q.size() != 6) begin
      $display("FAIL backpressure beat_count: got %0d required 6", data_q.size());
      errors++;
    end
    for (int k = 0; k < data_q.size() && k < 6; k++) begin
      checks++;
      if (data_q[k] !== beat_val(15'h0123, k) || last_q[k] !== (k == 5)) begin
        $display("FAIL backpressure beat%0d: got %h/%b required %h/%b",
                 k, data_q[k], last_q[k], beat_val(15'h0123, k), (k == 5));
        errors++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int beats_at_rst;
    m_tready = 1'b1;
    do_start(15'h0100, 16'd4);
    n = 0;
    while (data_q.size() < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (data_q.size() != 3) begin
      $display("FAIL reset_mid reach_beat3: got %0d beats required 3", data_q.size());
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({trace_buf_enb, m_tvalid, m_tlast, busy, done} !== 5'b0 || m_tdata !== 32'h0 || trace_buf_bram_addrb !== 15'h0) begin
      $display("FAIL reset_mid async: flags %b tdata %h addrb %h required 00000 0 0",
               {trace_buf_enb, m_tvalid, m_tlast, busy, done}, m_tdata, trace_buf_bram_addrb);
      errors++;
    end
    beats_at_rst = data_q.size();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (data_q.size() != beats_at_rst || busy !== 1'b0) begin
      $display("FAIL reset_mid abandon: beats %0d busy %b required %0d 0", data_q.size(), busy, beats_at_rst);
      errors++;
    end
    do_start(15'h0200, 16'd1);
    wait_done("reset_mid_restart", 100);
    checks++;
    if (data_q.size() != 6 || addr_q.size() != 1) begin
      $display("FAIL reset_mid restart_count: beats %0d reads %0d required 6 1", data_q.size(), addr_q.size());
      errors++;
    end
    for (int k = 0; k < data_q.size() && k < 6; k++) begin
      checks++;
      if (data_q[k] !== beat_val(15'h0200, k) || last_q[k] !== (k == 5)) begin
        $display("FAIL reset_mid restart_beat%0d: got %h/%b required %h/%b",
                 k, data_q[k], last_q[k], beat_val(15'h0200, k), (k == 5));
        errors++;
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [14:0] ea;
    m_tready = 1'b1;
    do_start(15'h0040, 16'd2);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL busy_start busy: got %b required 1", busy);
      errors++;
    end
    start_addr = 15'h0300;
    word_count = 16'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start", 200);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (addr_q.size() != 2 || addr_q[0] !== 15'h0040 || addr_q[1] !== 15'h0041) begin
      $display("FAIL busy_start addrb: got %0d reads required 2 reads 0040,0041", addr_q.size());
      errors++;
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0 || data_q.size() != 12) begin
      $display("FAIL busy_start tail: done %0d busy %b beats %0d required 1 0 12", done_cnt, busy, data_q.size());
      errors++;
    end
    for (int k = 0; k < data_q.size() && k < 12; k++) begin
      ea = 15'h0040 + 15'(k / 6);
      checks++;
      if (data_q[k] !== beat_val(ea, k % 6)) begin
        $display("FAIL busy_start beat%0d: got %h required %h", k, data_q[k], beat_val(ea, k % 6));
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    word_count = '0;
    m_tready = 1'b1;
    clear_mon();
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_two_words();
    test_zero_count();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
